ulx3s_clk_sequencer: RTL
========================

ULX3S_CLK_SEQUENCER -- requirements
Module: ulx3s_clk_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of clock-enable/reset domains (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, width of each per-channel divide ratio.
REQ-003 SHALL have parameter LOCK_FILTER, default 16, consecutive synchronised-lock cycles required before release (>=1).
REQ-004 SHALL have parameter STAGGER, default 4, cycles between successive channel reset releases (>=1).
REQ-005 SHALL have port clkin  in  1  single clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked  in  1  PLL LOCK, asynchronous to clkin.
REQ-008 SHALL have port div  in  CHANNELS*DIV_W  divide ratio per channel; channel k uses bits [k*DIV_W +: DIV_W].
REQ-009 SHALL have port rst_out  out  CHANNELS  active-high per-domain reset.
REQ-010 SHALL have port ce  out  CHANNELS  single-cycle clock-enable pulses.
REQ-011 SHALL have port ready  out  1  high when all domains are released.

Function
REQ-012 SHALL synchronise pll_locked through a 2-flop synchroniser to give sync_lock.
REQ-013 SHALL implement FSM states WAIT, FILTER, STAGGER, RUN.
REQ-014 WAIT: all rst_out=1, ce=0, ready=0; on sync_lock=1, go to FILTER with the filter counter at 1.
REQ-015 FILTER: counter increments while sync_lock=1; on reaching LOCK_FILTER, go to STAGGER and deassert rst_out[0] on that same edge.
REQ-016 STAGGER: deassert rst_out[k] exactly STAGGER edges after rst_out[k-1]; on the edge releasing rst_out[CHANNELS-1], set ready=1 and go to RUN.
REQ-017 CHANNELS=1: rst_out[0] and ready SHALL release on the same edge.
REQ-018 In FILTER, STAGGER or RUN, sync_lock=0 SHALL go to WAIT, set all rst_out=1, ce=0 and ready=0 on the next edge, and clear all counters.
REQ-019 Channel divider k SHALL run only while rst_out[k]=0; it holds 0 otherwise.
REQ-020 Divider k: ce[k]=1 for the one cycle where cnt_k >= div_k, cnt_k then wraps to 0; otherwise cnt_k increments. Period = div_k+1 cycles.
REQ-021 div_k=0 SHALL give ce[k]=1 on every cycle while released.
REQ-022 div SHALL be sampled live; if div_k is lowered below the current cnt_k, a ce pulse SHALL fire on the next cycle and the counter SHALL wrap.
REQ-023 The first ce[k] SHALL occur div_k cycles after the first cycle where rst_out[k]=0.
REQ-024 All outputs SHALL be driven directly from flops.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state=WAIT, synchroniser=0, all counters=0, rst_out=all ones, ce=0, ready=0.
REQ-026 Release of reset_n SHALL take effect on the first rising clkin edge after deassertion; no output changes before sync_lock rises.

Configuration
REQ-027 With CLKSEQ_LOSS_COUNT_EN defined, SHALL add output loss_count (out, 8 bits): it increments on each lock-loss transition to WAIT from FILTER, STAGGER or RUN, saturates at 255, and resets to 0.
REQ-028 Without CLKSEQ_LOSS_COUNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification (defaults: CHANNELS=4, LOCK_FILTER=16, STAGGER=4)
REQ-029 pll_locked rises, held steady -> rst_out[0] falls at edge 18, rst_out[1..3] at edges 22/26/30; ready=1 at edge 30.
REQ-030 pll_locked pulses high for 10 cycles, then goes low -> state returns to WAIT; rst_out stays 4'b1111; with the macro, loss_count=1.
REQ-031 In RUN, pll_locked drops -> 3 edges later rst_out=4'b1111, ce=0, ready=0; relock repeats REQ-029 timing.
REQ-032 div = {8'd0, 8'd1, 8'd3, 8'd255} in RUN -> ce[3] every cycle, ce[2] every 2, ce[1] every 4, ce[0] every 256.
REQ-033 ch1 div changes 200->10 while cnt=50 -> ce[1] pulses on the next cycle, then every 11 cycles.
REQ-034 reset_n asserted mid-STAGGER, between clock edges -> all outputs reach reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/ulx3s_clk_sequencer.sv
// PLL-lock gated reset sequencer with staggered per-domain release and clock-enable dividers.
// Define CLKSEQ_LOSS_COUNT_EN to add the saturating 8-bit loss_count output.
module ulx3s_clk_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_FILTER = 16,
  parameter int STAGGER     = 4
) (
  input  logic                      clkin,
  input  logic                      reset_n,
  input  logic                      pll_locked,
  input  logic [CHANNELS*DIV_W-1:0] div,
  output logic [CHANNELS-1:0]       rst_out,
  output logic [CHANNELS-1:0]       ce,
`ifdef CLKSEQ_LOSS_COUNT_EN
  output logic [7:0]                loss_count,
`endif
  output logic                      ready
);

  localparam int FCW = $clog2(LOCK_FILTER + 1);
  localparam int SCW = $clog2(STAGGER + 1);
  localparam int IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [FCW-1:0] FLAST = FCW'(LOCK_FILTER - 1);
  localparam logic [SCW-1:0] SLAST = SCW'(STAGGER - 1);
  localparam logic [IW-1:0]  ILAST = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_FILTER,
    ST_STAGGER,
    ST_RUN
  } state_t;

  state_t               state;
  logic                 sync_meta;
  logic                 sync_lock;
  logic [FCW-1:0]       fcnt;
  logic [SCW-1:0]       scnt;
  logic [IW-1:0]        idx;
  logic                 lost;
  logic [CHANNELS-1:0]  rel;
  logic [CHANNELS-1:0]  run;
  logic [DIV_W-1:0]     cnt [CHANNELS];

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_lock <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      sync_lock <= sync_meta;
    end
  end

  // rel marks channels leaving reset on this edge so dividers start in step
  always_comb begin
    lost = (state != ST_WAIT) && !sync_lock;
    rel  = '0;
    if (sync_lock) begin
      case (state)
        ST_WAIT:    rel[0] = (LOCK_FILTER == 1);
        ST_FILTER:  rel[0] = (fcnt == FLAST);
        ST_STAGGER: rel[idx] = (scnt == SLAST);
        default:    rel = '0;
      endcase
    end
    run = lost ? '0 : (~rst_out | rel);
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_WAIT;
      fcnt    <= '0;
      scnt    <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else if (lost) begin
      state   <= ST_WAIT;
      fcnt    <= '0;
      scnt    <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT, ST_FILTER: begin
          if (rel[0]) begin
            rst_out[0] <= 1'b0;
            idx        <= IW'(1);
            scnt       <= '0;
            fcnt       <= FCW'(LOCK_FILTER);
            if (CHANNELS == 1) begin
              ready <= 1'b1;
              state <= ST_RUN;
            end else begin
              state <= ST_STAGGER;
            end
          end else if (state == ST_FILTER) begin
            fcnt <= fcnt + 1'b1;
          end else if (sync_lock) begin
            fcnt  <= FCW'(1);
            state <= ST_FILTER;
          end
        end
        ST_STAGGER: begin
          if (scnt == SLAST) begin
            scnt         <= '0;
            rst_out[idx] <= 1'b0;
            idx          <= idx + 1'b1;
            if (idx == ILAST) begin
              ready <= 1'b1;
              state <= ST_RUN;
            end
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      ce <= '0;
      for (int k = 0; k < CHANNELS; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!run[k]) begin
          cnt[k] <= '0;
          ce[k]  <= 1'b0;
        end else if (cnt[k] >= div[k*DIV_W +: DIV_W]) begin
          cnt[k] <= '0;
          ce[k]  <= 1'b1;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
          ce[k]  <= 1'b0;
        end
      end
    end
  end

`ifdef CLKSEQ_LOSS_COUNT_EN
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      loss_count <= '0;
    end else if (lost && loss_count != 8'hFF) begin
      loss_count <= loss_count + 1'b1;
    end
  end
`endif

endmodule
